// File: rtl/ife_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ife_pkg
// Description : Shared types and helpers for the instruction-fetch block
//               splitter: FSM state encoding, parcel width, RVC detection.
// Revision    : 1.0 - initial release
// ============================================================================
package ife_pkg;

    localparam int PARCEL_W = 16;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_HOLD  = 2'd1,
        S_WAIT  = 2'd2
    } ife_split_state_t;

    // A parcel whose two low bits are not 2'b11 is a complete 16-bit instruction.
    function automatic logic is_rvc(input logic [15:0] parcel);
        return (parcel[1:0] != 2'b11);
    endfunction

endpackage : ife_pkg
`default_nettype wire

// File: rtl/ife_block_splitter_if.sv
`default_nettype none
// ============================================================================
// Module      : ife_block_splitter_if
// Description : Queue-side, redirect and instruction-side signals of the
//               block splitter. The slave modport is the splitter's view.
// Revision    : 1.0 - initial release
// ============================================================================
interface ife_block_splitter_if #(
    parameter int BLOCK_WIDTH = 128,
    parameter int ADDR_WIDTH  = 32
);
    logic [BLOCK_WIDTH-1:0] q_block;
    logic                   q_empty;
    logic                   q_pop;
    logic                   flush;
    logic [ADDR_WIDTH-1:0]  flush_pc;
    logic                   inst_valid;
    logic                   inst_ready;
    logic [31:0]            inst_data;
    logic [ADDR_WIDTH-1:0]  inst_pc;
    logic                   inst_is_rvc;

    modport master (
        output q_block, q_empty, flush, flush_pc, inst_ready,
        input  q_pop, inst_valid, inst_data, inst_pc, inst_is_rvc
    );

    modport slave (
        input  q_block, q_empty, flush, flush_pc, inst_ready,
        output q_pop, inst_valid, inst_data, inst_pc, inst_is_rvc
    );
endinterface : ife_block_splitter_if
`default_nettype wire

// File: rtl/ife_parcel_select.sv
`default_nettype none
// ============================================================================
// Module      : ife_parcel_select
// Description : Picks parcel ptr (and ptr+1) out of the buffered block and
//               forms the candidate instruction and its length.
// Revision    : 1.0 - initial release
// ============================================================================
module ife_parcel_select
    import ife_pkg::*;
#(
    parameter  int BLOCK_WIDTH = 128,
    localparam int c_nparcel   = BLOCK_WIDTH / PARCEL_W,
    localparam int c_ptr_w     = $clog2(c_nparcel)
) (
    input  wire logic [BLOCK_WIDTH-1:0] i_blk,
    input  wire logic [c_ptr_w-1:0]     i_ptr,
    output logic      [31:0]            o_cand_data,
    output logic                        o_cand_rvc
);

    logic [PARCEL_W-1:0] w_parcels [c_nparcel];
    logic [c_ptr_w-1:0]  w_ptr_hi;
    logic [PARCEL_W-1:0] w_lo;
    logic [PARCEL_W-1:0] w_hi;

    generate
        for (genvar gi = 0; gi < c_nparcel; gi++) begin : g_parcels
            assign w_parcels[gi] = i_blk[gi*PARCEL_W +: PARCEL_W];
        end
    endgenerate

    // The upper half wraps at the last parcel; that case is a straddle and
    // the caller never presents the wrapped value.
    assign w_ptr_hi = i_ptr + c_ptr_w'(1);

    // Candidate: zero-extended RVC parcel, or the two-parcel 32-bit word.
    always_comb begin
        w_lo        = w_parcels[i_ptr];
        w_hi        = w_parcels[w_ptr_hi];
        o_cand_rvc  = is_rvc(w_lo);
        o_cand_data = o_cand_rvc ? {16'h0000, w_lo} : {w_hi, w_lo};
    end

endmodule : ife_parcel_select
`default_nettype wire

// File: rtl/ife_block_splitter.sv
`default_nettype none
// ============================================================================
// Module      : ife_block_splitter
// Description : Splits 128-bit fetch blocks into one RISC-V instruction per
//               cycle (RVC and 32-bit, including block-straddling words),
//               with PC tracking and redirect support.
// Revision    : 1.0 - initial release
// ============================================================================
module ife_block_splitter
    import ife_pkg::*;
#(
    parameter int BLOCK_WIDTH = 128,
    parameter int ADDR_WIDTH  = 32
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    ife_block_splitter_if.slave bus
);

    localparam int c_nparcel     = BLOCK_WIDTH / PARCEL_W;
    localparam int c_block_bytes = BLOCK_WIDTH / 8;
    localparam int c_ptr_w       = $clog2(c_nparcel);
    localparam int c_ofs_w       = c_ptr_w + 1;
    localparam int c_adv_w       = c_ptr_w + 1;

    localparam logic [c_ptr_w-1:0]    c_last      = c_ptr_w'(c_nparcel - 1);
    localparam logic [c_adv_w-1:0]    c_nparcel_v = c_adv_w'(c_nparcel);
    localparam logic [ADDR_WIDTH-1:0] c_blk_step  = ADDR_WIDTH'(c_block_bytes);

    ife_split_state_t        r_state,     w_state_n;
    logic [BLOCK_WIDTH-1:0]  r_buf,       w_buf_n;
    logic [ADDR_WIDTH-1:0]   r_block_pc,  w_block_pc_n;
    logic [c_ptr_w-1:0]      r_ptr,       w_ptr_n;
    logic [c_ptr_w-1:0]      r_start_ptr, w_start_ptr_n;
    logic [PARCEL_W-1:0]     r_lo,        w_lo_n;
    logic                    r_str_pend,  w_str_pend_n;

    logic [31:0]             w_cand_data;
    logic                    w_cand_rvc;
    logic                    w_straddle;
    logic                    w_valid;
    logic                    w_hs;
    logic                    w_pop;
    logic [31:0]             w_data;
    logic [ADDR_WIDTH-1:0]   w_pc;
    logic                    w_rvc;
    logic [c_adv_w-1:0]      w_sum;

    // Bit 0 of the redirect target is meaningless for 16-bit aligned code.
    logic w_unused_ok;
    assign w_unused_ok = bus.flush_pc[0];

    ife_parcel_select #(
        .BLOCK_WIDTH (BLOCK_WIDTH)
    ) u_parcel_select (
        .i_blk       (r_buf),
        .i_ptr       (r_ptr),
        .o_cand_data (w_cand_data),
        .o_cand_rvc  (w_cand_rvc)
    );

    // Presentation decode: everything below depends only on registered state.
    always_comb begin
        w_straddle = (r_state == S_HOLD) && !r_str_pend && !w_cand_rvc && (r_ptr == c_last);
        w_valid    = (r_state == S_HOLD) && !w_straddle;
        w_data     = r_str_pend ? {r_buf[PARCEL_W-1:0], r_lo} : w_cand_data;
        w_rvc      = !r_str_pend && w_cand_rvc;
        w_pc       = r_str_pend ? (r_block_pc - ADDR_WIDTH'(2))
                                : (r_block_pc + ADDR_WIDTH'({r_ptr, 1'b0}));
        w_hs       = w_valid && bus.inst_ready;
        w_sum      = {1'b0, r_ptr} + (w_cand_rvc ? c_adv_w'(1) : c_adv_w'(2));
    end

    assign bus.inst_valid  = w_valid;
    assign bus.inst_data   = w_valid ? w_data : 32'h0;
    assign bus.inst_pc     = w_valid ? w_pc : '0;
    assign bus.inst_is_rvc = w_valid && w_rvc;
    assign bus.q_pop       = w_pop;

    // Next-state and pop logic; a redirect overrides every other action.
    always_comb begin
        w_state_n     = r_state;
        w_buf_n       = r_buf;
        w_block_pc_n  = r_block_pc;
        w_ptr_n       = r_ptr;
        w_start_ptr_n = r_start_ptr;
        w_lo_n        = r_lo;
        w_str_pend_n  = r_str_pend;
        w_pop         = 1'b0;

        if (bus.flush) begin
            w_block_pc_n  = {bus.flush_pc[ADDR_WIDTH-1:c_ofs_w], {c_ofs_w{1'b0}}};
            w_start_ptr_n = bus.flush_pc[c_ofs_w-1:1];
            w_str_pend_n  = 1'b0;
            w_state_n     = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (!bus.q_empty) begin
                        w_pop         = 1'b1;
                        w_buf_n       = bus.q_block;
                        w_ptr_n       = r_start_ptr;
                        w_start_ptr_n = '0;
                        w_state_n     = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (w_straddle) begin
                        // Low half latched; the high half is parcel 0 of the next block.
                        w_lo_n = w_cand_data[PARCEL_W-1:0];
                        if (!bus.q_empty) begin
                            w_pop        = 1'b1;
                            w_buf_n      = bus.q_block;
                            w_block_pc_n = r_block_pc + c_blk_step;
                            w_str_pend_n = 1'b1;
                            w_ptr_n      = '0;
                        end else begin
                            w_state_n = S_WAIT;
                        end
                    end else if (w_hs) begin
                        if (r_str_pend) begin
                            w_ptr_n      = c_ptr_w'(1);
                            w_str_pend_n = 1'b0;
                        end else if (w_sum == c_nparcel_v) begin
                            w_block_pc_n = r_block_pc + c_blk_step;
                            w_ptr_n      = '0;
                            if (!bus.q_empty) begin
                                w_pop   = 1'b1;
                                w_buf_n = bus.q_block;
                            end else begin
                                w_state_n = S_EMPTY;
                            end
                        end else begin
                            w_ptr_n = w_sum[c_ptr_w-1:0];
                        end
                    end
                end
                S_WAIT: begin
                    if (!bus.q_empty) begin
                        w_pop        = 1'b1;
                        w_buf_n      = bus.q_block;
                        w_block_pc_n = r_block_pc + c_blk_step;
                        w_str_pend_n = 1'b1;
                        w_ptr_n      = '0;
                        w_state_n    = S_HOLD;
                    end
                end
                default: begin
                    w_state_n = S_EMPTY;
                end
            endcase
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_EMPTY;
            r_buf       <= '0;
            r_block_pc  <= '0;
            r_ptr       <= '0;
            r_start_ptr <= '0;
            r_lo        <= '0;
            r_str_pend  <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_buf       <= w_buf_n;
            r_block_pc  <= w_block_pc_n;
            r_ptr       <= w_ptr_n;
            r_start_ptr <= w_start_ptr_n;
            r_lo        <= w_lo_n;
            r_str_pend  <= w_str_pend_n;
        end
    end

endmodule : ife_block_splitter
`default_nettype wire

// File: tb/tb_ife_block_splitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ife_block_splitter
// Description : Directed, table-driven bench for ife_block_splitter with a
//               small queue model feeding blocks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ife_block_splitter;

    localparam int BW = 128;
    localparam int AW = 32;

    typedef struct {
        int          push_id;
        logic        flush;
        logic [31:0] fpc;
        logic        ready;
        logic        exp_pop;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic [31:0] exp_pc;
        logic        exp_rvc;
    } vec_t;

    logic clk;
    logic rst_n;

    ife_block_splitter_if #(.BLOCK_WIDTH(BW), .ADDR_WIDTH(AW)) bus ();

    ife_block_splitter #(
        .BLOCK_WIDTH (BW),
        .ADDR_WIDTH  (AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [BW-1:0] blk [6];
    logic [BW-1:0] tb_q [$];
    vec_t          vecs [$];
    int            n_pass  = 0;
    int            n_total = 0;
    int            cyc     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
        else
            n_pass++;
    endtask

    task automatic sync_q();
        bus.q_empty = (tb_q.size() == 0);
        bus.q_block = (tb_q.size() == 0) ? '0 : tb_q[0];
    endtask

    task automatic add(input int p, input logic f, input logic [31:0] fpc, input logic r,
                       input logic ep, input logic ev, input logic [31:0] ed,
                       input logic [31:0] epc, input logic er);
        vec_t v;
        v.push_id = p; v.flush = f; v.fpc = fpc; v.ready = r;
        v.exp_pop = ep; v.exp_valid = ev; v.exp_data = ed; v.exp_pc = epc; v.exp_rvc = er;
        vecs.push_back(v);
    endtask

    // One cycle: push, drive at negedge, check, then let the edge pop the model.
    task automatic run_vec(input vec_t v);
        logic pop_s;
        @(negedge clk);
        if (v.push_id >= 0) tb_q.push_back(blk[v.push_id]);
        bus.flush      = v.flush;
        bus.flush_pc   = v.fpc;
        bus.inst_ready = v.ready;
        sync_q();
        #1;
        chk("q_pop", 32'(bus.q_pop), 32'(v.exp_pop));
        chk("inst_valid", 32'(bus.inst_valid), 32'(v.exp_valid));
        if (v.exp_valid) begin
            chk("inst_data", bus.inst_data, v.exp_data);
            chk("inst_pc", bus.inst_pc, v.exp_pc);
            chk("inst_is_rvc", 32'(bus.inst_is_rvc), 32'(v.exp_rvc));
        end
        pop_s = bus.q_pop;
        @(posedge clk);
        #1;
        if (pop_s && tb_q.size() > 0) void'(tb_q.pop_front());
        sync_q();
        cyc++;
    endtask

    initial begin
        vec_t v;
        rst_n          = 1'b0;
        bus.flush      = 1'b0;
        bus.flush_pc   = '0;
        bus.inst_ready = 1'b1;
        sync_q();

        // Block contents, parcel k at bits [16k+15:16k].
        blk[0] = {32'h00400213, 32'h00300193, 32'h00200113, 32'h00100093};
        for (int k = 0; k < 8; k++) begin
            blk[1][16*k +: 16] = 16'h4501;
            blk[2][16*k +: 16] = 16'h0001 | 16'(k << 8);
            blk[4][16*k +: 16] = 16'h0001 | 16'(k << 8);
            blk[5][16*k +: 16] = 16'hDEAD;
        end
        blk[2][16*7 +: 16] = 16'h0073;
        blk[3] = {16'h0073, 16'h0000, 16'h0013, 16'h8082,
                  16'h4505, 16'h00A0, 16'h0513, 16'h0010};
        blk[4][15:0] = 16'h0020;
        blk[5][16*5 +: 16] = 16'h4581;
        blk[5][16*6 +: 16] = 16'h0093;
        blk[5][16*7 +: 16] = 16'h0050;

        // Reset values.
        #12;
        chk("rst q_pop", 32'(bus.q_pop), 32'h0);
        chk("rst inst_valid", 32'(bus.inst_valid), 32'h0);
        chk("rst inst_data", bus.inst_data, 32'h0);
        chk("rst inst_pc", bus.inst_pc, 32'h0);
        chk("rst inst_is_rvc", 32'(bus.inst_is_rvc), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: four 32-bit instructions at 0x1000
        add(-1, 1, 32'h1000, 1, 0, 0, 0, 0, 0);
        add( 0, 0, 0, 1, 1, 0, 0, 0, 0);
        add(-1, 0, 0, 1, 0, 1, 32'h00100093, 32'h1000, 0);
        add(-1, 0, 0, 1, 0, 1, 32'h00200113, 32'h1004, 0);
        add(-1, 0, 0, 1, 0, 1, 32'h00300193, 32'h1008, 0);
        add(-1, 0, 0, 1, 0, 1, 32'h00400213, 32'h100C, 0);
        add(-1, 0, 0, 1, 0, 0, 0, 0, 0);
        // 2: eight RVC parcels; next block arrives on the last one (no bubble)
        add( 1, 0, 0, 1, 1, 0, 0, 0, 0);
        for (int k = 0; k < 7; k++)
            add(-1, 0, 0, 1, 0, 1, 32'h00004501, 32'h1010 + 32'(2*k), 1);
        add( 2, 0, 0, 1, 1, 1, 32'h00004501, 32'h101E, 1);
        // 3: straddle with the next block already queued
        for (int k = 0; k < 7; k++)
            add(-1, 0, 0, 1, 0, 1, 32'h0001 | 32'(k << 8), 32'h1020 + 32'(2*k), 1);
        add( 3, 0, 0, 1, 1, 0, 0, 0, 0);
        add(-1, 0, 0, 1, 0, 1, 32'h00100073, 32'h102E, 0);
        add(-1, 0, 0, 1, 0, 1, 32'h00A00513, 32'h1032, 0);
        add(-1, 0, 0, 1, 0, 1, 32'h00004505, 32'h1036, 1);
        add(-1, 0, 0, 1, 0, 1, 32'h00008082, 32'h1038, 1);
        add(-1, 0, 0, 1, 0, 1, 32'h00000013, 32'h103A, 0);
        // 4: straddle with the queue empty for three cycles
        for (int k = 0; k < 3; k++)
            add(-1, 0, 0, 1, 0, 0, 0, 0, 0);
        add( 4, 0, 0, 1, 1, 0, 0, 0, 0);
        add(-1, 0, 0, 1, 0, 1, 32'h00200073, 32'h103E, 0);
        add(-1, 0, 0, 1, 0, 1, 32'h00000101, 32'h1042, 1);
        // 6: stall four cycles, then flush while a block waits in the queue
        for (int k = 0; k < 4; k++)
            add(-1, 0, 0, 0, 0, 1, 32'h00000201, 32'h1044, 1);
        add( 5, 1, 32'h200A, 0, 0, 1, 32'h00000201, 32'h1044, 1);
        // 5: redirect to 0x200A starts at parcel 5
        add(-1, 0, 0, 1, 1, 0, 0, 0, 0);
        add(-1, 0, 0, 1, 0, 1, 32'h00004581, 32'h200A, 1);
        add(-1, 0, 0, 1, 0, 1, 32'h00500093, 32'h200C, 0);
        add(-1, 0, 0, 1, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++)
            run_vec(vecs[i]);

        // Asynchronous reset mid-block drops inst_valid at once.
        v = '{push_id: 1, flush: 0, fpc: 0, ready: 0, exp_pop: 1, exp_valid: 0,
              exp_data: 0, exp_pc: 0, exp_rvc: 0};
        run_vec(v);
        @(negedge clk);
        chk("pre-reset inst_valid", 32'(bus.inst_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst inst_valid", 32'(bus.inst_valid), 32'h0);
        chk("async rst inst_pc", bus.inst_pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        // After reset block_pc is 0 and start_ptr is 0.
        v = '{push_id: 0, flush: 0, fpc: 0, ready: 1, exp_pop: 1, exp_valid: 0,
              exp_data: 0, exp_pc: 0, exp_rvc: 0};
        run_vec(v);
        v = '{push_id: -1, flush: 0, fpc: 0, ready: 1, exp_pop: 0, exp_valid: 1,
              exp_data: 32'h00100093, exp_pc: 32'h0, exp_rvc: 0};
        run_vec(v);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_ife_block_splitter
`default_nettype wire
